bin_to_bcd_seq: RTL and testbench
=================================

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, binary input width in bits (legal: 1 to 64).
REQ-002 SHALL provide parameter DIGITS, default 10, number of BCD output digits (legal: 1 to 20).
REQ-003 SHALL provide port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL provide port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL provide port start  input  1  request a conversion of binary.
REQ-006 SHALL provide port binary  input  WIDTH  unsigned value to convert, sampled only when start is accepted.
REQ-007 SHALL provide port busy  output  1  conversion in progress.
REQ-008 SHALL provide port done  output  1  one-cycle pulse when a new result is presented.
REQ-009 SHALL provide port bcd  output  4*DIGITS  result; digit i occupies bits [4i+3:4i]; digit 0 is the ones digit.
REQ-010 SHALL provide port lead_zero  output  DIGITS  bit i=1 when digit i and all higher digits are zero; bit 0 is always 0.
REQ-011 SHALL provide port overflow  output  1  value did not fit in DIGITS digits.

Function
REQ-012 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-013 SHALL accept start in IDLE or DONE only: on that edge, capture binary into a shift register, clear the working digits and the overflow accumulator, load the bit counter with WIDTH, and go to SHIFT.
REQ-014 SHALL ignore start while in SHIFT; no restart, and the captured operand is unchanged.
REQ-015 SHALL perform exactly one double-dabble step per clock in SHIFT:
  - add 3 to every working digit >= 5;
  - shift the whole digit chain left one bit;
  - shift in the operand MSB at digit 0 bit 0;
  - shift the operand left and decrement the counter.
REQ-016 SHALL OR into the overflow accumulator any 1 shifted out of the top digit's bit 3 during a step.
REQ-017 SHALL, on the edge completing step WIDTH:
  - load bcd, lead_zero and overflow from the working state;
  - go to DONE.
REQ-018 SHALL assert busy exactly while in SHIFT: high for WIDTH cycles after the accepting edge.
REQ-019 SHALL assert done only in DONE. DONE lasts one cycle, then goes to IDLE, or to SHIFT if start is asserted.
REQ-020 SHALL give latency WIDTH+1 edges from the accepting edge to the edge that ends the done pulse; results become visible WIDTH edges after acceptance.
REQ-021 SHALL hold bcd, lead_zero and overflow stable between updates; the previous result stays valid during SHIFT.
REQ-022 SHALL produce bcd equal to binary mod 10^DIGITS when overflow=1, and exact decimal otherwise.
REQ-023 SHALL size the bit counter as ceil(log2(WIDTH+1)) bits; no wrap occurs within a conversion.
REQ-024 SHALL convert binary=0 to bcd=0, lead_zero with all bits above bit 0 set, and overflow=0.

Reset
REQ-025 SHALL, while reset=1, immediately force: state IDLE, busy=0, done=0, bcd=0, overflow=0, counter=0, lead_zero = all ones except bit 0.
REQ-026 SHALL, on reset during SHIFT, abandon the conversion with no done pulse and no output update; the first edge after release accepts a new start.

Verification
REQ-027 SHALL cover: WIDTH=8, DIGITS=3, binary=8'hFF, start pulse -> busy high 8 cycles, done pulse on cycle 9, bcd=12'h255, lead_zero=3'b000, overflow=0.
REQ-028 SHALL cover: defaults, binary=32'hFFFFFFFF -> bcd=40'h4294967295, overflow=0; then binary=0 -> bcd=0, lead_zero=10'h3FE.
REQ-029 SHALL cover: WIDTH=8, DIGITS=2, binary=200 -> bcd=8'h00, overflow=1, lead_zero=2'b10; and binary=7 -> bcd=8'h07, lead_zero=2'b10, overflow=0.
REQ-030 SHALL cover: start held high throughout SHIFT with binary changing -> result reflects the first captured value; back-to-back conversion starts from DONE with no IDLE cycle.
REQ-031 SHALL cover: reset asserted asynchronously mid-SHIFT (between edges) -> outputs at reset values immediately, no done pulse; the next conversion of 8'd99 (WIDTH=8, DIGITS=3) -> bcd=12'h099, lead_zero=3'b100.
REQ-032 SHALL check every conversion against a reference model (value mod 10^DIGITS, overflow = value >= 10^DIGITS) in a randomized run of at least 1000 conversions.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter: one double-dabble step per clock, WIDTH steps per result.
// Outputs are registered and hold the last completed result until the next one lands.
module bin_to_bcd_seq #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      binary,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     lead_zero,
    output logic                  overflow
);

    localparam int unsigned       CntW    = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0]   CntLoad = CntW'(WIDTH);
    localparam logic [DIGITS-1:0] LzReset = ~DIGITS'(1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     op_q, op_d;
    logic [4*DIGITS-1:0]  dig_q, dig_d;
    logic                 acc_q, acc_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [4*DIGITS-1:0]  bcd_q, bcd_d;
    logic [DIGITS-1:0]    lz_q, lz_d;
    logic                 ovf_q, ovf_d;

    logic [4*DIGITS-1:0]  adj;
    logic [4*DIGITS-1:0]  stepped;
    logic [DIGITS-1:0]    stepped_lz;
    logic                 zero_above;

    // One double-dabble step applied to the current working digits.
    always_comb begin
        adj = dig_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
            end
        end
        stepped = {adj[4*DIGITS-2:0], op_q[WIDTH-1]};

        stepped_lz = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above    = zero_above & (stepped[4*i +: 4] == 4'd0);
            stepped_lz[i] = zero_above;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        dig_d   = dig_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
        lz_d    = lz_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle, StDone: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d = StShift;
                    op_d    = binary;
                    dig_d   = '0;
                    acc_d   = 1'b0;
                    cnt_d   = CntLoad;
                    busy_d  = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                op_d  = op_q << 1;
                dig_d = stepped;
                // A set bit 3 leaving the top digit means the value reached 10^DIGITS.
                acc_d = acc_q | adj[4*DIGITS-1];
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    bcd_d   = stepped;
                    lz_d    = stepped_lz;
                    ovf_d   = acc_q | adj[4*DIGITS-1];
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= '0;
            dig_q   <= '0;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            lz_q    <= LzReset;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dig_q   <= dig_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
            lz_q    <= lz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign bcd       = bcd_q;
    assign lead_zero = lz_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: three parameterisations checked every cycle against an
// arithmetic model, plus directed vectors with hand-computed results.
module tb_bin_to_bcd_seq;

    localparam int NI = 3;
    localparam int unsigned WID [NI] = '{8, 32, 8};
    localparam int unsigned DIG [NI] = '{3, 10, 2};

    logic        clk;
    logic        reset;
    logic        start [NI];
    logic [63:0] bin [NI];
    logic        d_busy [NI];
    logic        d_done [NI];
    logic        d_ovf [NI];
    logic [11:0] bcd_a;
    logic [39:0] bcd_b;
    logic [7:0]  bcd_c;
    logic [2:0]  lz_a;
    logic [9:0]  lz_b;
    logic [1:0]  lz_c;

    int n_err = 0;
    int n_chk = 0;

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_a (
        .clk(clk), .reset(reset), .start(start[0]), .binary(bin[0][7:0]),
        .busy(d_busy[0]), .done(d_done[0]), .bcd(bcd_a), .lead_zero(lz_a),
        .overflow(d_ovf[0])
    );

    bin_to_bcd_seq u_b (
        .clk(clk), .reset(reset), .start(start[1]), .binary(bin[1][31:0]),
        .busy(d_busy[1]), .done(d_done[1]), .bcd(bcd_b), .lead_zero(lz_b),
        .overflow(d_ovf[1])
    );

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) u_c (
        .clk(clk), .reset(reset), .start(start[2]), .binary(bin[2][7:0]),
        .busy(d_busy[2]), .done(d_done[2]), .bcd(bcd_c), .lead_zero(lz_c),
        .overflow(d_ovf[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic longint unsigned pow10(input int unsigned k);
        longint unsigned p = 1;
        for (int j = 0; j < int'(k); j++) p = p * 10;
        return p;
    endfunction

    function automatic logic [79:0] to_bcd(input longint unsigned v, input int unsigned d);
        logic [79:0]     b = '0;
        longint unsigned r = v;
        for (int k = 0; k < int'(d); k++) begin
            b[4*k +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return b;
    endfunction

    function automatic logic [79:0] lz_of(input longint unsigned v, input int unsigned d);
        logic [79:0] z = '0;
        for (int k = 1; k < int'(d); k++) z[k] = ((v / pow10(k)) == 0);
        return z;
    endfunction

    function automatic logic [79:0] act_bcd(input int i);
        case (i)
            0:       return 80'(bcd_a);
            1:       return 80'(bcd_b);
            default: return 80'(bcd_c);
        endcase
    endfunction

    function automatic logic [79:0] act_lz(input int i);
        case (i)
            0:       return 80'(lz_a);
            1:       return 80'(lz_b);
            default: return 80'(lz_c);
        endcase
    endfunction

    // Model: a request seen while not converting is taken; WIDTH cycles later the
    // arithmetic result appears together with a one-cycle done.
    logic            m_busy [NI];
    logic            m_done [NI];
    logic            m_ovf [NI];
    logic [79:0]     m_bcd [NI];
    logic [79:0]     m_lz [NI];
    int unsigned     m_left [NI];
    longint unsigned m_val [NI];

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < NI; i++) begin
            if (reset) begin
                m_busy[i] <= 1'b0;
                m_done[i] <= 1'b0;
                m_ovf[i]  <= 1'b0;
                m_bcd[i]  <= '0;
                m_lz[i]   <= lz_of(0, DIG[i]);
                m_left[i] <= 0;
            end else if (m_busy[i]) begin
                m_left[i] <= m_left[i] - 1;
                if (m_left[i] == 1) begin
                    m_busy[i] <= 1'b0;
                    m_done[i] <= 1'b1;
                    m_bcd[i]  <= to_bcd(m_val[i] % pow10(DIG[i]), DIG[i]);
                    m_lz[i]   <= lz_of(m_val[i] % pow10(DIG[i]), DIG[i]);
                    m_ovf[i]  <= (m_val[i] >= pow10(DIG[i]));
                end
            end else begin
                m_done[i] <= 1'b0;
                if (start[i]) begin
                    m_busy[i] <= 1'b1;
                    m_left[i] <= WID[i];
                    m_val[i]  <= bin[i] & ((64'd1 << WID[i]) - 64'd1);
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("busy%0d", i), 80'(d_busy[i]), 80'(m_busy[i]));
            chk($sformatf("done%0d", i), 80'(d_done[i]), 80'(m_done[i]));
            chk($sformatf("ovf%0d", i), 80'(d_ovf[i]), 80'(m_ovf[i]));
            chk($sformatf("bcd%0d", i), act_bcd(i), m_bcd[i]);
            chk($sformatf("lz%0d", i), act_lz(i), m_lz[i]);
        end
    end

    // Returns at the negedge where done is visible; n = negedges spent waiting.
    task automatic wait_done(input int i, output int n, output int nbusy);
        n = 0;
        nbusy = 0;
        while (!d_done[i] && n < 100) begin
            if (d_busy[i]) nbusy++;
            @(negedge clk);
            n++;
        end
        chk($sformatf("done_seen%0d", i), 80'(d_done[i]), 80'd1);
    endtask

    task automatic run_conv(input int i, input logic [63:0] v, output int n, output int nb);
        @(negedge clk);
        start[i] = 1'b1;
        bin[i]   = v;
        @(negedge clk);
        start[i] = 1'b0;
        wait_done(i, n, nb);
    endtask

    task automatic run_all(input logic [63:0] v0, input logic [63:0] v1, input logic [63:0] v2);
        logic [2:0] seen = '0;
        int         n = 0;
        @(negedge clk);
        bin[0] = v0;
        bin[1] = v1;
        bin[2] = v2;
        for (int i = 0; i < NI; i++) start[i] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NI; i++) start[i] = 1'b0;
        while (n < 100) begin
            for (int i = 0; i < NI; i++) if (d_done[i]) seen[i] = 1'b1;
            if (seen == 3'b111) break;
            @(negedge clk);
            n++;
        end
        chk("all_done", 80'(seen), 80'(3'b111));
    endtask

    int n, nb;

    initial begin
        reset = 1'b0;
        for (int i = 0; i < NI; i++) begin
            start[i] = 1'b0;
            bin[i]   = '0;
        end
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_lz_a", 80'(lz_a), 80'(3'b110));
        chk("rst_lz_b", 80'(lz_b), 80'(10'h3FE));
        chk("rst_lz_c", 80'(lz_c), 80'(2'b10));
        chk("rst_bcd_b", 80'(bcd_b), 80'd0);
        #1 reset = 1'b0;

        // 8-bit, 3 digits: 255
        run_conv(0, 64'hFF, n, nb);
        chk("ff_busy_cycles", 80'(nb), 80'd8);
        chk("ff_done_cycle", 80'(n + 1), 80'd9);
        chk("ff_bcd", 80'(bcd_a), 80'(12'h255));
        chk("ff_lz", 80'(lz_a), 80'(3'b000));
        chk("ff_ovf", 80'(d_ovf[0]), 80'd0);

        // Asynchronous reset between edges during a conversion
        @(negedge clk);
        start[0] = 1'b1;
        bin[0]   = 64'd77;
        @(negedge clk);
        start[0] = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", 80'(d_busy[0]), 80'd0);
        chk("arst_done", 80'(d_done[0]), 80'd0);
        chk("arst_bcd", 80'(bcd_a), 80'd0);
        chk("arst_lz", 80'(lz_a), 80'(3'b110));
        chk("arst_ovf", 80'(d_ovf[0]), 80'd0);
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        start[0] = 1'b1;
        bin[0]   = 64'd99;
        @(negedge clk);
        start[0] = 1'b0;
        chk("post_rst_busy", 80'(d_busy[0]), 80'd1);
        wait_done(0, n, nb);
        chk("d99_bcd", 80'(bcd_a), 80'(12'h099));
        chk("d99_lz", 80'(lz_a), 80'(3'b100));

        // Defaults: full-scale and zero
        run_conv(1, 64'hFFFF_FFFF, n, nb);
        chk("max_bcd", 80'(bcd_b), 80'(40'h42_9496_7295));
        chk("max_ovf", 80'(d_ovf[1]), 80'd0);
        chk("max_cycles", 80'(nb), 80'd32);
        run_conv(1, 64'd0, n, nb);
        chk("zero_bcd", 80'(bcd_b), 80'd0);
        chk("zero_lz", 80'(lz_b), 80'(10'h3FE));
        chk("zero_ovf", 80'(d_ovf[1]), 80'd0);

        // 8-bit, 2 digits: overflow and in-range
        run_conv(2, 64'd200, n, nb);
        chk("d200_bcd", 80'(bcd_c), 80'(8'h00));
        chk("d200_ovf", 80'(d_ovf[2]), 80'd1);
        chk("d200_lz", 80'(lz_c), 80'(2'b10));
        run_conv(2, 64'd7, n, nb);
        chk("d7_bcd", 80'(bcd_c), 80'(8'h07));
        chk("d7_lz", 80'(lz_c), 80'(2'b10));
        chk("d7_ovf", 80'(d_ovf[2]), 80'd0);

        // Start held through SHIFT with a moving operand, then restart from DONE
        @(negedge clk);
        start[0] = 1'b1;
        bin[0]   = 64'd123;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bin[0] = 64'($urandom_range(0, 255));
        end
        @(negedge clk);
        chk("held_done", 80'(d_done[0]), 80'd1);
        chk("held_bcd", 80'(bcd_a), 80'(12'h123));
        chk("held_lz", 80'(lz_a), 80'(3'b000));
        bin[0] = 64'd45;
        @(negedge clk);
        chk("b2b_busy", 80'(d_busy[0]), 80'd1);
        chk("b2b_done", 80'(d_done[0]), 80'd0);
        start[0] = 1'b0;
        wait_done(0, n, nb);
        chk("b2b_bcd", 80'(bcd_a), 80'(12'h045));
        chk("b2b_lz", 80'(lz_a), 80'(3'b100));

        // Randomised conversions on all three instances
        for (int r = 0; r < 1000; r++) begin
            run_all(64'($urandom_range(0, 255)), 64'($urandom), 64'($urandom_range(0, 255)));
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
